// File: rtl/ccp_msg_arb.sv
// Per-source message FIFOs merged onto one channel by a round-robin arbiter that holds its offer until accepted.
// Define CCP_ARB_BYPASS_EN for a zero-latency input-to-output path while every FIFO is empty.
`ifndef MSG_WIDTH
`define MSG_WIDTH 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef TAG_WIDTH
`define TAG_WIDTH 8
`endif

module ccp_msg_arb #(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MSG_W      = `MSG_WIDTH,
  parameter int DATA_W     = `DATA_WIDTH,
  parameter int TAG_W      = `TAG_WIDTH,
  localparam int SRC_W     = $clog2(NUM_SRC),
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        in_valid,
  output logic [NUM_SRC-1:0]        in_ready,
  input  logic [NUM_SRC*MSG_W-1:0]  in_type,
  input  logic [NUM_SRC*DATA_W-1:0] in_data,
  input  logic [NUM_SRC*TAG_W-1:0]  in_tag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [MSG_W-1:0]          out_type,
  output logic [DATA_W-1:0]         out_data,
  output logic [TAG_W-1:0]          out_tag,
  output logic [SRC_W-1:0]          out_source,
  output logic [NUM_SRC*CNT_W-1:0]  fifo_count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = MSG_W + DATA_W + TAG_W;

  typedef enum logic [1:0] {IDLE, OFFER, HOLD} state_t;
  state_t state, state_nxt;

  logic [ENT_W-1:0]   mem [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr [NUM_SRC];
  logic [PTR_W-1:0]   rd_ptr [NUM_SRC];
  logic [CNT_W-1:0]   count [NUM_SRC];
  logic [CNT_W-1:0]   count_nxt [NUM_SRC];
  logic [NUM_SRC-1:0] nonempty, push, pop;
  logic [SRC_W-1:0]   rr_ptr, hold_src, sel_src, rr_nxt;
  logic               sel_valid, sel_bypass, handshake, any_next;
  logic [ENT_W-1:0]   sel_ent;

  function automatic logic [SRC_W-1:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                               input logic [SRC_W-1:0]   ptr);
    logic             found;
    logic [SRC_W-1:0] pick;
    logic [SRC_W-1:0] sidx;
    int unsigned      idx;
    found = 1'b0;
    pick  = ptr;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx  = (32'(ptr) + k) % NUM_SRC;
      sidx = SRC_W'(idx);
      if (!found && req[sidx]) begin
        found = 1'b1;
        pick  = sidx;
      end
    end
    return pick;
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      nonempty[i] = (count[i] != '0);
      in_ready[i] = (count[i] != CNT_W'(FIFO_DEPTH));
      fifo_count[i*CNT_W +: CNT_W] = count[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    any_next = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++)
      any_next = any_next | (count_nxt[i] != '0);
    state_nxt = IDLE;
    if (sel_valid && !out_ready) state_nxt = HOLD;
    else if (any_next)           state_nxt = OFFER;
  end

  always_comb begin
    sel_bypass = 1'b0;
    sel_valid  = |nonempty;
    sel_src    = (state == HOLD) ? hold_src : rr_pick(nonempty, rr_ptr);
    sel_ent    = mem[sel_src][rd_ptr[sel_src]];
`ifdef CCP_ARB_BYPASS_EN
    if (!(|nonempty) && (|in_valid)) begin
      sel_valid  = 1'b1;
      sel_bypass = 1'b1;
      sel_src    = rr_pick(in_valid, rr_ptr);
      sel_ent    = {in_type[sel_src*MSG_W +: MSG_W], in_data[sel_src*DATA_W +: DATA_W],
                    in_tag[sel_src*TAG_W +: TAG_W]};
    end
`endif
    handshake  = sel_valid & out_ready;
    out_valid  = sel_valid;
    {out_type, out_data, out_tag} = sel_valid ? sel_ent : '0;
    out_source = sel_valid ? sel_src : '0;
    rr_nxt     = (sel_src == SRC_W'(NUM_SRC - 1)) ? '0 : sel_src + 1'b1;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      push[i] = in_valid[i] & in_ready[i];
      pop[i]  = handshake & ~sel_bypass & (sel_src == SRC_W'(i));
    end
    // A bypassed winner that is accepted immediately never lands in its FIFO.
    if (sel_bypass && out_ready) push[sel_src] = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++)
      count_nxt[i] = count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      hold_src <= '0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        count[i]  <= '0;
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
      end
    end else begin
      if (handshake)              rr_ptr   <= rr_nxt;
      if (sel_valid && !out_ready) hold_src <= sel_src;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
        count[i] <= count_nxt[i];
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NUM_SRC; i++)
      if (push[i])
        mem[i][wr_ptr[i]] <= {in_type[i*MSG_W +: MSG_W], in_data[i*DATA_W +: DATA_W],
                              in_tag[i*TAG_W +: TAG_W]};
  end
endmodule

// File: tb/tb_ccp_msg_arb.sv
// Scoreboard bench for ccp_msg_arb: directed traffic queues expected {source, tag} handshakes,
// a negedge monitor pops and compares each accepted output.
module tb_ccp_msg_arb;
  localparam int NS = 4, FD = 4, MW = 4, DW = 32, TW = 8, SW = 2, CW = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NS-1:0]    in_valid = '0;
  logic [NS-1:0]    in_ready;
  logic [NS*MW-1:0] in_type = '0;
  logic [NS*DW-1:0] in_data = '0;
  logic [NS*TW-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [MW-1:0]    out_type;
  logic [DW-1:0]    out_data;
  logic [TW-1:0]    out_tag;
  logic [SW-1:0]    out_source;
  logic [NS*CW-1:0] fifo_count;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q [$];
  logic [15:0] mon_e;

  always #5 clk = ~clk;

  ccp_msg_arb #(.NUM_SRC(NS), .FIFO_DEPTH(FD), .MSG_W(MW), .DATA_W(DW), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_type(in_type),
    .in_data(in_data), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_type(out_type), .out_data(out_data), .out_tag(out_tag), .out_source(out_source),
    .fifo_count(fifo_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] cnt(input int s);
    return fifo_count[s*CW +: CW];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int s, input logic [7:0] tag);
    in_valid[s]         = 1'b1;
    in_type[s*MW +: MW] = MW'(s);
    in_data[s*DW +: DW] = 32'hD000_0000 | {24'h0, tag};
    in_tag[s*TW +: TW]  = tag;
  endtask

  task automatic clr_in();
    in_valid = '0;
  endtask

  task automatic expect_msg(input int s, input logic [7:0] tag);
    exp_q.push_back({8'(s), tag});
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (out_valid && n < budget) begin
      tick();
      n++;
    end
    check("drain_done", {63'h0, out_valid}, 64'h0);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual src=%0d tag=%0h required no output", out_source, out_tag);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_source", 64'(out_source), 64'(mon_e[15:8]));
          check("out_tag", 64'(out_tag), 64'(mon_e[7:0]));
          check("out_type", 64'(out_type), 64'(mon_e[11:8]));
          check("out_data", 64'(out_data), 64'(32'hD000_0000 | {24'h0, mon_e[7:0]}));
        end
      end else if (!out_valid) begin
        check("idle_fields", 64'({out_type, out_data, out_tag, out_source}), 64'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst = 1'b0;
    #2;
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'hF);
    check("rst_fifo_count", 64'(fifo_count), 64'h0);
    check("rst_out_fields", 64'({out_type, out_data, out_tag, out_source}), 64'h0);
    tick();
    tick();
    rst = 1'b1;

    // Round robin: every source pushes two messages, sink always ready.
    out_ready = 1'b1;
    for (int r = 0; r < 2; r++)
      for (int s = 0; s < NS; s++) expect_msg(s, 8'(s*16 + r));
    for (int s = 0; s < NS; s++) set_in(s, 8'(s*16));
    tick();
    for (int s = 0; s < NS; s++) set_in(s, 8'(s*16 + 1));
    tick();
    clr_in();
    wait_idle(20);
    check("rr_counts_empty", 64'(fifo_count), 64'h0);

    // Full FIFO on source 2 with the sink stalled.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set_in(2, 8'(8'h40 + k));
      if (k < 4) expect_msg(2, 8'(8'h40 + k));
      tick();
      check("full_count2", 64'(cnt(2)), 64'((k < 4) ? k + 1 : 4));
      check("full_in_ready2", {63'h0, in_ready[2]}, {63'h0, (k < 3)});
    end
    clr_in();
    out_ready = 1'b1;
    wait_idle(20);

    // HOLD: source 1 offered and stalled while source 0 keeps pushing.
    out_ready = 1'b0;
    set_in(1, 8'h50);
    expect_msg(1, 8'h50);
    tick();
    clr_in();
    check("hold_valid", {63'h0, out_valid}, 64'h1);
    check("hold_src0", 64'(out_source), 64'h1);
    for (int k = 0; k < 3; k++) begin
      set_in(0, 8'(8'h60 + k));
      expect_msg(0, 8'(8'h60 + k));
      tick();
      check("hold_src", 64'(out_source), 64'h1);
      check("hold_tag", 64'(out_tag), 64'h50);
    end
    clr_in();
    out_ready = 1'b1;
    wait_idle(20);

    // Simultaneous push/pop on FIFO3 across the pointer wrap.
    out_ready = 1'b0;
    set_in(3, 8'h0A); expect_msg(3, 8'h0A); tick();
    set_in(3, 8'h0B); expect_msg(3, 8'h0B); tick();
    clr_in();
    check("wrap_count_pre", 64'(cnt(3)), 64'h2);
    set_in(3, 8'h0C); expect_msg(3, 8'h0C);
    out_ready = 1'b1;
    tick();
    clr_in();
    check("wrap_count_pushpop", 64'(cnt(3)), 64'h2);
    wait_idle(20);

    // Latency from an empty arbiter: same cycle with bypass, one cycle later without.
    set_in(1, 8'h77);
    expect_msg(1, 8'h77);
    #3;
`ifdef CCP_ARB_BYPASS_EN
    check("lat_valid_same", {63'h0, out_valid}, 64'h1);
    check("lat_src_same", 64'(out_source), 64'h1);
`else
    check("lat_valid_same", {63'h0, out_valid}, 64'h0);
`endif
    tick();
    clr_in();
`ifdef CCP_ARB_BYPASS_EN
    check("lat_count1", 64'(cnt(1)), 64'h0);
    check("lat_valid_next", {63'h0, out_valid}, 64'h0);
`else
    check("lat_count1", 64'(cnt(1)), 64'h1);
    check("lat_valid_next", {63'h0, out_valid}, 64'h1);
`endif
    wait_idle(20);

    // Asynchronous reset mid-traffic with FIFO0 holding three messages.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      set_in(0, 8'(8'h80 + k));
      tick();
    end
    clr_in();
    check("pre_rst_count0", 64'(cnt(0)), 64'h3);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("mid_rst_fifo_count", 64'(fifo_count), 64'h0);
    check("mid_rst_in_ready", 64'(in_ready), 64'hF);
    check("mid_rst_fields", 64'({out_type, out_data, out_tag, out_source}), 64'h0);
    tick();
    rst = 1'b1;
    set_in(2, 8'h90);
    expect_msg(2, 8'h90);
    tick();
    clr_in();
    check("post_rst_count2", 64'(cnt(2)), 64'h1);
    check("post_rst_src", 64'(out_source), 64'h2);
    out_ready = 1'b1;
    wait_idle(20);

    check("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ccp_msg_arb.md
CCP_MSG_ARB -- requirements
Module: ccp_msg_arb

Interface
REQ-001 Parameter NUM_SRC, default 4, is the number of cache source channels (2..16).
REQ-002 Parameter FIFO_DEPTH, default 4, is the entries per source FIFO (power of two, 2..16).
REQ-003 Parameter MSG_W, default `MSG_WIDTH, is the message type width.
REQ-004 Parameter DATA_W, default `DATA_WIDTH, is the message data width.
REQ-005 Parameter TAG_W, default `TAG_WIDTH, is the message tag width.
REQ-006 Parameter SRC_W is derived as $clog2(NUM_SRC) and is not overridable.
REQ-007 clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 rst  input  1  one clock; reset is asynchronous and active-low.
REQ-009 in_valid  input  NUM_SRC  per-source message valid; bit i belongs to source i.
REQ-010 in_ready  output  NUM_SRC  per-source accept; equals NOT full of FIFO i.
REQ-011 in_type  input  NUM_SRC*MSG_W  flattened per-source message types; slice i is source i.
REQ-012 in_data  input  NUM_SRC*DATA_W  flattened per-source data.
REQ-013 in_tag  input  NUM_SRC*TAG_W  flattened per-source tags.
REQ-014 out_valid  output  1  merged channel holds a message.
REQ-015 out_ready  input  1  L2 accepts the merged message.
REQ-016 out_type, out_data, out_tag  output  MSG_W/DATA_W/TAG_W  selected message fields.
REQ-017 out_source  output  SRC_W  index of the source owning the presented message.
REQ-018 fifo_count  output  NUM_SRC*($clog2(FIFO_DEPTH)+1)  per-source occupancy.

Function
REQ-019 Push to FIFO i occurs when in_valid[i] and in_ready[i] are both 1 at a clock edge; the message is stored in arrival order.
REQ-020 Push into a full FIFO is impossible: in_ready[i] is 0 while count[i]==FIFO_DEPTH, and in_valid[i] is then ignored.
REQ-021 Push and pop of the same FIFO in one cycle leave its count unchanged; this is legal at any count from 1 to FIFO_DEPTH-1, and at FIFO_DEPTH only the pop takes effect.
REQ-022 out_valid is 1 whenever any FIFO is non-empty.
REQ-023 Arbiter states: IDLE (out_valid 0), OFFER (selection computed this cycle), and HOLD (out_valid 1, out_ready 0 on the previous edge).
REQ-024 In OFFER, the arbiter selects the first non-empty FIFO searching upward from rr_ptr, wrapping modulo NUM_SRC.
REQ-025 HOLD locks out_source and all out_* fields stable until the handshake completes, regardless of new arrivals at other sources.
REQ-026 A handshake (out_valid and out_ready) pops the selected FIFO and sets rr_ptr to (out_source+1) mod NUM_SRC.
REQ-027 Without a handshake, rr_ptr does not change.
REQ-028 Without bypass, minimum latency from push to out_valid is 1 cycle.
REQ-029 Sustained throughput is one message per cycle while out_ready is 1.
REQ-030 FIFO pointers wrap modulo FIFO_DEPTH.
REQ-031 out_* fields are don't-care while out_valid is 0, but the bench checks them against 0.

Reset
REQ-032 Assertion of rst (low) immediately clears all FIFO counts and pointers, sets rr_ptr to 0, and releases HOLD, independent of clk.
REQ-033 During reset, out_valid is 0 and in_ready is all-ones.
REQ-034 During reset, fifo_count is 0 and out_type, out_data, out_tag and out_source are 0.
REQ-035 Messages in flight when reset asserts mid-operation are discarded; no partial handshake completes.
REQ-036 The first push is accepted on the first rising edge after rst deasserts.

Configuration
REQ-037 Macro CCP_ARB_BYPASS_EN enables zero-latency bypass.
REQ-038 With CCP_ARB_BYPASS_EN defined and all FIFOs empty, a valid input is presented combinationally on out_* in the same cycle, with round-robin arbitration from rr_ptr among the in_valid bits.
REQ-039 Under bypass, if out_ready is 1 the winner is consumed without a FIFO write; if out_ready is 0 it is written to its FIFO and HOLD is entered.
REQ-040 With CCP_ARB_BYPASS_EN undefined, no input-to-output combinational path exists, and REQ-028 applies.

Verification
REQ-041 Reset check: drive rst low mid-traffic with FIFO0 at count 3 -> out_valid=0, fifo_count all 0, and in_ready=4'b1111 before the next clk edge.
REQ-042 Round-robin fairness: NUM_SRC=4, all sources push 2 messages, out_ready held at 1 -> out_source sequence is 0,1,2,3,0,1,2,3.
REQ-043 Full FIFO: FIFO_DEPTH=4, source 2 pushes 5 messages with out_ready=0 -> in_ready[2]=0 after the 4th push, the 5th is not accepted, and fifo_count[2]=4.
REQ-044 HOLD stability: source 1 is presented with out_ready=0 for 3 cycles while source 0 pushes -> out_source stays 1 and out_tag stays unchanged; after the handshake, the next out_source is 2 if non-empty, else 0.
REQ-045 Simultaneous push/pop: FIFO3 at count 2, push and pop in one cycle -> fifo_count[3] stays 2, and data order is preserved across pointer wrap (tags 0xA, 0xB, 0xC out in order).
REQ-046 Bypass: with CCP_ARB_BYPASS_EN defined, all FIFOs empty, in_valid[1]=1 and out_ready=1 -> out_valid=1 in the same cycle with out_source=1 and fifo_count[1] staying 0; with the macro undefined -> out_valid rises one cycle later.
